// File: rtl/whack_pkg.sv
// ============================================================================
// Module : whack_pkg
// Brief  : Shared types, seven-segment constants and BCD helpers for the
//          whack-a-mole game/score stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    // Active-low, bit0 = segment a ... bit6 = segment g
    localparam seg_t c_SEG_BLANK = 7'b1111111;
    localparam seg_t c_SEG_0     = 7'b1000000;
    localparam seg_t c_SEG_1     = 7'b1111001;
    localparam seg_t c_SEG_2     = 7'b0100100;
    localparam seg_t c_SEG_3     = 7'b0110000;
    localparam seg_t c_SEG_4     = 7'b0011001;
    localparam seg_t c_SEG_5     = 7'b0010010;
    localparam seg_t c_SEG_6     = 7'b0000010;
    localparam seg_t c_SEG_7     = 7'b1111000;
    localparam seg_t c_SEG_8     = 7'b0000000;
    localparam seg_t c_SEG_9     = 7'b0010000;

    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Three packed BCD digits {hundreds, tens, units}, saturating at 999
    function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Saturating at 000
    function automatic logic [11:0] bcd3_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h000) begin
            if (v[3:0] != 4'd0) begin
                r[3:0] = v[3:0] - 4'd1;
            end else begin
                r[3:0] = 4'd9;
                if (v[7:4] != 4'd0) begin
                    r[7:4] = v[7:4] - 4'd1;
                end else begin
                    r[7:4]  = 4'd9;
                    r[11:8] = v[11:8] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module : bcd_to_seg
// Brief  : Combinational BCD digit to active-low seven-segment code; >9 blanks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import whack_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/game_score_timer.sv
// ============================================================================
// Module : game_score_timer
// Brief  : Countdown timer, BCD score and IDLE/RUN/END sequencing feeding the
//          seven-segment driver. Optional macro: SCORE_PENALTY_EN (miss scoring).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_score_timer
    import whack_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
)(
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic [3:0] time_set10,
    input  logic [3:0] time_set1,
    output logic       gamestart,
    output logic       gameend,
    output logic [6:0] score100,
    output logic [6:0] score10,
    output logic [6:0] score1,
    output logic [6:0] time10,
    output logic [6:0] time1,
    output logic       tick
);

    localparam int             c_PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [11:0]     r_score;
    bcd_t            r_time10;
    bcd_t            r_time1;
    logic [c_PW-1:0] r_presc;
    logic            r_tick;

    bcd_t w_set10;
    bcd_t w_set1;
    logic w_set_zero;
    logic w_wrap;
    logic w_last;
    logic w_up;
    logic w_dn;
    bcd_t w_disp10;
    bcd_t w_disp1;

    assign w_set10    = bcd_clamp(time_set10);
    assign w_set1     = bcd_clamp(time_set1);
    assign w_set_zero = (w_set10 == 4'd0) && (w_set1 == 4'd0);
    assign w_wrap     = (r_presc == c_PRESC_MAX);
    assign w_last     = (r_time10 == 4'd0) && (r_time1 == 4'd1);

`ifdef SCORE_PENALTY_EN
    assign w_up = hit & ~miss;
    assign w_dn = miss & ~hit;
`else
    logic w_unused_miss;
    assign w_unused_miss = miss;
    assign w_up = hit;
    assign w_dn = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_set_zero ? ST_END : ST_RUN;
            ST_RUN:  if (w_wrap && w_last) w_state_nxt = ST_END;
            ST_END:  if (start) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_score  <= 12'h000;
            r_time10 <= 4'd0;
            r_time1  <= 4'd0;
            r_presc  <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_time10 <= w_set10;
                        r_time1  <= w_set1;
                        r_score  <= 12'h000;
                        r_presc  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_wrap) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        if (r_time1 == 4'd0) begin
                            r_time1  <= 4'd9;
                            r_time10 <= r_time10 - 4'd1;
                        end else begin
                            r_time1 <= r_time1 - 4'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                    if (w_up) begin
                        r_score <= bcd3_inc(r_score);
                    end else if (w_dn) begin
                        r_score <= bcd3_dec(r_score);
                    end
                end
                ST_END: begin
                    if (start) r_score <= 12'h000;
                end
                default: ;
            endcase
        end
    end

    // IDLE previews the requested game length; otherwise show the live count
    assign w_disp10 = (r_state == ST_IDLE) ? w_set10 : r_time10;
    assign w_disp1  = (r_state == ST_IDLE) ? w_set1  : r_time1;

    assign gamestart = (r_state != ST_IDLE);
    assign gameend   = (r_state == ST_END);
    assign tick      = r_tick;

    bcd_to_seg u_seg_s100 (.i_bcd(r_score[11:8]), .o_seg(score100));
    bcd_to_seg u_seg_s10  (.i_bcd(r_score[7:4]),  .o_seg(score10));
    bcd_to_seg u_seg_s1   (.i_bcd(r_score[3:0]),  .o_seg(score1));
    bcd_to_seg u_seg_t10  (.i_bcd(w_disp10),      .o_seg(time10));
    bcd_to_seg u_seg_t1   (.i_bcd(w_disp1),       .o_seg(time1));

endmodule

`default_nettype wire

// File: tb/tb_game_score_timer.sv
// ============================================================================
// Module : tb_game_score_timer
// Brief  : Directed self-checking bench for game_score_timer (TICK_DIV = 20).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_score_timer;

    localparam int TD = 20;
`ifdef SCORE_PENALTY_EN
    localparam bit c_PEN = 1'b1;
`else
    localparam bit c_PEN = 1'b0;
`endif

    logic       CLK100MHZ = 1'b0;
    logic       reset;
    logic       start;
    logic       hit;
    logic       miss;
    logic [3:0] time_set10;
    logic [3:0] time_set1;
    logic       gamestart;
    logic       gameend;
    logic [6:0] score100;
    logic [6:0] score10;
    logic [6:0] score1;
    logic [6:0] time10;
    logic [6:0] time1;
    logic       tick;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         cnt    = 0;
    logic [6:0] seg_tab [10];

    always #5 CLK100MHZ = ~CLK100MHZ;

    game_score_timer #(.TICK_DIV(TD)) u_dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .start      (start),
        .hit        (hit),
        .miss       (miss),
        .time_set10 (time_set10),
        .time_set1  (time_set1),
        .gamestart  (gamestart),
        .gameend    (gameend),
        .score100   (score100),
        .score10    (score10),
        .score1     (score1),
        .time10     (time10),
        .time1      (time1),
        .tick       (tick)
    );

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic chk_score(input string tag, input int v);
        chk({tag, ".s100"}, score100, seg_tab[v / 100]);
        chk({tag, ".s10"},  score10,  seg_tab[(v / 10) % 10]);
        chk({tag, ".s1"},   score1,   seg_tab[v % 10]);
    endtask

    task automatic chk_time(input string tag, input int v);
        chk({tag, ".t10"}, time10, seg_tab[v / 10]);
        chk({tag, ".t1"},  time1,  seg_tab[v % 10]);
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
        cnt++;
    endtask

    task automatic run_to(input int n);
        while (cnt < n) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        reset = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;
        time_set10 = 4'd0; time_set1 = 4'd5;
        step(); step();
        chk("rst.gamestart", gamestart, 0);
        chk("rst.gameend", gameend, 0);
        chk("rst.tick", tick, 0);
        chk_score("rst", 0);
        chk_time("rst", 5);
        reset = 1'b0;

        time_set10 = 4'd12; time_set1 = 4'd15; #1;
        chk_time("clamp", 99);
        time_set10 = 4'd0; time_set1 = 4'd5; #1;

        // 5 s game: one tick every TD cycles, END at 5*TD
        pulse_start();
        chk("g5.gamestart", gamestart, 1);
        chk_time("g5.load", 5);
        for (int s = 4; s >= 0; s--) begin
            run_to((5 - s) * TD - 1);
            chk("g5.pre_tick", tick, 0);
            chk("g5.pre_end", gameend, 0);
            step();
            chk("g5.tick", tick, 1);
            chk_time("g5.time", s);
            chk("g5.gameend", gameend, (s == 0));
        end
        step();
        chk("g5.tick_1cyc", tick, 0);
        chk("g5.end_hold", gameend, 1);
        chk_time("g5.end_time", 0);
        pulse_start();
        chk("g5.to_idle", gamestart, 0);
        chk_score("g5.idle", 0);

        // 30 s game: borrow on first tick, hits, then mid-game reset
        time_set10 = 4'd3; time_set1 = 4'd0;
        pulse_start();
        hit = 1'b1;
        run_to(10);
        hit = 1'b0;
        run_to(TD);
        chk("g30.tick", tick, 1);
        chk_time("g30.borrow", 29);
        hit = 1'b1;
        run_to(52);
        hit = 1'b0;
        chk_score("g30.s42", 42);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("g30.rst.gamestart", gamestart, 0);
        chk("g30.rst.gameend", gameend, 0);
        chk_score("g30.rst", 0);
        chk_time("g30.rst", 30);

        // Score saturation at 999
        time_set10 = 4'd9; time_set1 = 4'd9;
        pulse_start();
        hit = 1'b1;
        run_to(1005);
        hit = 1'b0;
        chk_score("sat", 999);
        step();
        chk_score("sat.hold", 999);
        chk("sat.run", gameend, 0);
        reset = 1'b1; step(); reset = 1'b0;

        // Zero-length game goes straight to END
        time_set10 = 4'd0; time_set1 = 4'd0;
        pulse_start();
        chk("zero.gamestart", gamestart, 1);
        chk("zero.gameend", gameend, 1);
        chk_time("zero", 0);
        pulse_start();
        chk("zero.idle", gamestart, 0);

        // Hit on the final tick counts; END ignores hit/miss
        time_set10 = 4'd0; time_set1 = 4'd1;
        pulse_start();
        run_to(TD - 1);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk("fin.gameend", gameend, 1);
        chk("fin.tick", tick, 1);
        chk_score("fin", 1);
        hit = 1'b1; step(); hit = 1'b0;
        chk_score("fin.end_hit", 1);
        miss = 1'b1; step(); miss = 1'b0;
        chk_score("fin.end_miss", 1);
        pulse_start();
        chk("fin.idle", gamestart, 0);
        chk_score("fin.idle", 0);

        // Miss handling depends on SCORE_PENALTY_EN
        time_set10 = 4'd0; time_set1 = 4'd2;
        pulse_start();
        hit = 1'b1; step(); hit = 1'b0;
        chk_score("pen.hit", 1);
        hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
        chk_score("pen.both", c_PEN ? 1 : 2);
        miss = 1'b1; step(); miss = 1'b0;
        chk_score("pen.miss1", c_PEN ? 0 : 2);
        miss = 1'b1; step(); miss = 1'b0;
        chk_score("pen.miss2", c_PEN ? 0 : 2);
        chk("pen.run", gameend, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_score_timer.md
# game_score_timer

Game-state and scoring stage that sits directly upstream of the seven-segment display driver. It runs the countdown timer, counts hits into a 3-digit BCD score and sequences the game through idle, running and ended states. It presents every displayed digit as an active-low seven-segment code, together with the `gamestart` and `gameend` flags the display driver consumes.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per 1 s countdown tick; must be ≥ 2.
- `CLK100MHZ` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; starts a game or returns from the ended state.
- `hit` in 1: one-cycle pulse, one successful whack.
- `miss` in 1: one-cycle pulse, wrong whack; used only with `SCORE_PENALTY_EN`.
- `time_set10` in 4: BCD tens digit of the game length.
- `time_set1` in 4: BCD units digit of the game length.
- `gamestart` out 1: high in RUN and END.
- `gameend` out 1: high in END only.
- `score100`, `score10`, `score1` out 7 each: seven-segment codes for the score digits.
- `time10`, `time1` out 7 each: seven-segment codes for the time digits.
- `tick` out 1: one-cycle pulse at each second boundary in RUN, for the mole generator.

## Operation
- **States:** IDLE, RUN, END.
- **IDLE**
  - Time digits show `time_set10`/`time_set1`, each clamped to 9 if the input exceeds 9.
  - Score shows 000.
- **IDLE → RUN on `start`**
  - Loads the clamped set time.
  - Clears the score and the prescaler.
  - If the loaded time is 00, the block goes IDLE → END directly.
- **RUN**
  - The prescaler counts 0..TICK_DIV-1 and pulses `tick` on wrap.
  - Each tick decrements the BCD time: units 0 borrows from tens and sets units to 9.
  - The tick that takes the time to 00 moves the block to END.
- **RUN, scoring**
  - `hit` increments the score as 3-digit BCD with carries, saturating at 999.
  - `start` is ignored in RUN.
- **END**
  - Time is held at 00 and the score is frozen.
  - `hit` and `miss` are ignored.
  - `start` moves the block to IDLE and clears the score.
- **Simultaneous events**
  - A `hit` in the same cycle as the final tick is counted.
  - `hit` together with `tick` in RUN: both take effect.
- **Segment encoding**
  - Active-low; bit0 = segment a … bit6 = segment g.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Reset**
  - Applied at any time, including mid-game: the block goes to IDLE.
  - Score and time registers are cleared to 0 and the prescaler is cleared.
  - Outputs after reset: `gamestart`=0, `gameend`=0, `tick`=0, score codes=1000000, time codes show the clamped set time.

## Timing
- All state, score, time and prescaler registers update on the rising edge of `CLK100MHZ`.
- Segment codes are combinational from the BCD registers:
  - a `hit` sampled at edge N is visible on the outputs after edge N.
- `tick` is a registered pulse high for exactly one cycle.
  - The time decrement appears on the same edge that raises `tick`.
- First tick occurs TICK_DIV cycles after the `start` edge. A game of T seconds reaches END exactly T·TICK_DIV cycles after `start`.
- `gameend` rises on the same edge on which the time reaches 00.

## Configuration
- **`SCORE_PENALTY_EN` defined:**
  - `miss` in RUN decrements the BCD score, saturating at 000.
  - `hit` and `miss` in the same cycle leave the score unchanged.
- **`SCORE_PENALTY_EN` undefined:**
  - `miss` is ignored entirely.
  - The score is monotonic non-decreasing within a game.

## Structure
- **Shared package `whack_pkg`:**
  - state enum (IDLE/RUN/END);
  - BCD digit typedef (4 bits);
  - seven-segment code typedef (7 bits);
  - blank constant 7'b1111111 and the digit-code constants.
- **Sub-module `bcd_to_seg`:** pure combinational, 4-bit BCD in, 7-bit active-low code out (values >9 give blank). Instantiated five times.

## Test plan
- Reset, then set time 0/5 and pulse `start` with TICK_DIV=10 → `gamestart`=1; `time1` steps 5→4→…→0 every 10 cycles; `gameend`=1 exactly 50 cycles after `start`.
- Time set 3/0 with TICK_DIV=4 → after 4 cycles the time digits read 2/9 (borrow); reaches 00 at 120 cycles.
- 1000 `hit` pulses during RUN → score reads 999 (codes 0010000 ×3) and stays 999.
- `hit` coincident with the final tick → score incremented and `gameend`=1 on the same edge. A later `hit` in END → no change. `start` in END → IDLE, score 000.
- `SCORE_PENALTY_EN`: score 001, two `miss` pulses → 000 then held at 000. `hit`+`miss` in the same cycle → unchanged. Without the macro: `miss` has no effect.
- `reset` asserted mid-RUN with score 042 → next edge: IDLE, `gamestart`=0, `gameend`=0, score codes 1000000.
